// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: state encoding and slice width.
package nibble_serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Index counter width: enough for NIBBLES-1, never narrower than one bit.
  function automatic int idx_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Request/result bundle between a client and the nibble-serial adder.
interface nibble_serial_adder_if #(
  parameter int NIBBLES = 4
);
  import nibble_serial_adder_pkg::*;

  localparam int W = NIBBLE_W * NIBBLES;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/full_adder_4bit_bh.sv
// Behavioural 4-bit full adder shared by the nibble-serial datapath.
module full_adder_4bit_bh (
  output logic [3:0] s,
  output logic       cout,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder that feeds one nibble per clock through a single 4-bit adder,
// chaining the carry through a register and publishing the result on completion.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | waiting for start
// ST_ADD  | adding nibble idx, LSB first
// ST_DONE | one-cycle completion; may accept a new start
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  nibble_serial_adder_if.slave bus
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = idx_width(NIBBLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  state_t             state, state_nx;
  logic               accept;
  logic               last;

  logic [W-1:0]       op_a, op_b;
  logic               carry;
  logic [IDX_W-1:0]   idx;
  logic [W-1:0]       res, res_nx;

  logic [W-1:0]       sum_q;
  logic               cout_q;
  logic               busy_q, done_q;

  logic [NIBBLE_W-1:0] fa_a, fa_b, fa_s;
  logic                fa_cout;

  assign last = (idx == IDX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = ST_IDLE;
    accept   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          accept   = 1'b1;
          state_nx = ST_ADD;
        end
      end
      ST_ADD: begin
        state_nx = last ? ST_DONE : ST_ADD;
      end
      ST_DONE: begin
        if (bus.start) begin
          accept   = 1'b1;
          state_nx = ST_ADD;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign fa_a = op_a[idx*NIBBLE_W +: NIBBLE_W];
  assign fa_b = op_b[idx*NIBBLE_W +: NIBBLE_W];

  full_adder_4bit_bh u_fa (
    .s    (fa_s),
    .cout (fa_cout),
    .a    (fa_a),
    .b    (fa_b),
    .cin  (carry)
  );

  // The final nibble is merged here so sum can be published on the same edge it is produced.
  always_comb begin
    res_nx = res;
    res_nx[idx*NIBBLE_W +: NIBBLE_W] = fa_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a   <= '0;
      op_b   <= '0;
      carry  <= 1'b0;
      idx    <= '0;
      res    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (accept) begin
      op_a  <= bus.a;
      op_b  <= bus.b;
      carry <= bus.cin;
      idx   <= '0;
      res   <= '0;
    end else if (state == ST_ADD) begin
      res   <= res_nx;
      carry <= fa_cout;
      if (last) begin
        idx    <= '0;
        sum_q  <= res_nx;
        cout_q <= fa_cout;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_nx == ST_ADD);
      done_q <= (state_nx == ST_DONE);
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule
